// File: rtl/store_buffer_fwd.sv
// DEPTH-entry in-order store buffer with optional same-word coalescing, a
// valid/ready drain port and byte-granular youngest-wins load forwarding.
module store_buffer_fwd #(
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int COALESCE_EN = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        st_valid,
  output logic                        st_ready,
  input  logic [ADDR_WIDTH-1:0]       st_addr,
  input  logic [DATA_WIDTH-1:0]       st_data,
  input  logic [DATA_WIDTH/8-1:0]     st_be,
  input  logic                        ld_valid,
  input  logic [ADDR_WIDTH-1:0]       ld_addr,
  input  logic [DATA_WIDTH/8-1:0]     ld_be,
  output logic                        ld_hit,
  output logic                        ld_hit_reserve,
  output logic [DATA_WIDTH-1:0]       ld_data,
  output logic                        drain_valid,
  input  logic                        drain_ready,
  output logic [ADDR_WIDTH-1:0]       drain_addr,
  output logic [DATA_WIDTH-1:0]       drain_data,
  output logic [DATA_WIDTH/8-1:0]     drain_be,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty,
  output logic                        full
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_WIDTH - OFF;

  logic [WA_W-1:0]       word_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [BE_W-1:0]       be_q   [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PTR_W-1:0]      head_q, tail_q, youngest_s, idx_s;
  logic [CNT_W-1:0]      count_q;
  logic [WA_W-1:0]       st_word_s, ld_word_s;
  logic                  push_s, pop_s, coal_s, alloc_s;
  logic [BE_W-1:0]       cov_s;
  logic [DATA_WIDTH-1:0] fwd_s;
  logic                  unused_addr_bits;

  assign st_word_s        = st_addr[ADDR_WIDTH-1:OFF];
  assign ld_word_s        = ld_addr[ADDR_WIDTH-1:OFF];
  assign unused_addr_bits = ^{st_addr[OFF-1:0], ld_addr[OFF-1:0]};

  assign count       = count_q;
  assign empty       = (count_q == {CNT_W{1'b0}});
  assign full        = (count_q == CNT_W'(DEPTH));
  assign st_ready    = !full;
  assign drain_valid = !empty;
  assign drain_addr  = {word_q[head_q], {OFF{1'b0}}};
  assign drain_data  = data_q[head_q];
  assign drain_be    = be_q[head_q];

  // With count >= 2 the youngest entry is never the head, so merging keeps the drain port stable.
  assign youngest_s = tail_q - PTR_W'(1);
  assign push_s     = st_valid && st_ready;
  assign pop_s      = drain_valid && drain_ready;
  assign coal_s     = (COALESCE_EN != 0) && push_s && (count_q >= CNT_W'(2)) &&
                      valid_q[youngest_s] && (word_q[youngest_s] == st_word_s);
  assign alloc_s    = push_s && !coal_s;

  // Queue state: allocate/merge at the tail, retire at the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      valid_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= {WA_W{1'b0}};
        data_q[i] <= {DATA_WIDTH{1'b0}};
        be_q[i]   <= {BE_W{1'b0}};
      end
    end else begin
      if (alloc_s) begin
        word_q[tail_q]  <= st_word_s;
        data_q[tail_q]  <= st_data;
        be_q[tail_q]    <= st_be;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (coal_s) begin
        for (int b = 0; b < BE_W; b++) begin
          if (st_be[b]) begin
            data_q[youngest_s][8*b +: 8] <= st_data[8*b +: 8];
          end
        end
        be_q[youngest_s] <= be_q[youngest_s] | st_be;
      end
      if (pop_s) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      case ({alloc_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Forwarding search walks oldest to youngest so younger lanes overwrite older ones.
  always_comb begin
    cov_s = {BE_W{1'b0}};
    fwd_s = {DATA_WIDTH{1'b0}};
    idx_s = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_q + PTR_W'(i);
      for (int b = 0; b < BE_W; b++) begin
        if (valid_q[idx_s] && (word_q[idx_s] == ld_word_s) && be_q[idx_s][b] && ld_be[b]) begin
          cov_s[b]          = 1'b1;
          fwd_s[8*b +: 8]   = data_q[idx_s][8*b +: 8];
        end else begin
          cov_s[b]          = cov_s[b];
        end
      end
    end
  end

  assign ld_hit         = ld_valid && (ld_be != {BE_W{1'b0}}) && (cov_s == ld_be);
  assign ld_hit_reserve = ld_valid && (cov_s != {BE_W{1'b0}}) && (cov_s != ld_be);
  assign ld_data        = ld_valid ? fwd_s : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Directed bench for store_buffer_fwd: table-driven load lookups plus
// sequences for reset, backpressure, coalescing and wrap-around.
module tb_store_buffer_fwd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0, ld_valid = 1'b0, drain_ready = 1'b0;
  logic [31:0] st_addr = 32'h0, st_data = 32'h0, ld_addr = 32'h0;
  logic [3:0]  st_be = 4'h0, ld_be = 4'h0;
  logic        st_ready, ld_hit, ld_hit_reserve, drain_valid, empty, full;
  logic [31:0] ld_data, drain_addr, drain_data;
  logic [3:0]  drain_be, count;
  logic        nc_st_ready, nc_ld_hit, nc_ld_res, nc_dv, nc_empty, nc_full;
  logic [31:0] nc_ld_data, nc_daddr, nc_ddata;
  logic [3:0]  nc_dbe, nc_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_buffer_fwd #(.DEPTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32), .COALESCE_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
    .ld_hit(ld_hit), .ld_hit_reserve(ld_hit_reserve), .ld_data(ld_data),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
    .drain_data(drain_data), .drain_be(drain_be), .count(count), .empty(empty), .full(full));

  store_buffer_fwd #(.DEPTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32), .COALESCE_EN(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(nc_st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
    .ld_hit(nc_ld_hit), .ld_hit_reserve(nc_ld_res), .ld_data(nc_ld_data),
    .drain_valid(nc_dv), .drain_ready(drain_ready), .drain_addr(nc_daddr),
    .drain_data(nc_ddata), .drain_be(nc_dbe), .count(nc_count), .empty(nc_empty), .full(nc_full));

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [3:0]  be;
    logic        hit;
    logic        res;
    logic [31:0] d;
  } ld_vec_t;

  ld_vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    st_valid = 1'b0; ld_valid = 1'b0; drain_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
    tick();
    st_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_a [3];
    logic [31:0] exp_d [3];
    logic [3:0]  exp_b [3];

    tbl[0] = '{1'b1, 32'h40, 4'hF, 1'b1, 1'b0, 32'h11111122};
    tbl[1] = '{1'b1, 32'h40, 4'h1, 1'b1, 1'b0, 32'h00000022};
    tbl[2] = '{1'b1, 32'h42, 4'hC, 1'b1, 1'b0, 32'h11110000};
    tbl[3] = '{1'b1, 32'h80, 4'hF, 1'b0, 1'b1, 32'h0000ABCD};
    tbl[4] = '{1'b1, 32'h80, 4'h1, 1'b1, 1'b0, 32'h000000CD};
    tbl[5] = '{1'b1, 32'h84, 4'hF, 1'b0, 1'b0, 32'h00000000};
    tbl[6] = '{1'b1, 32'h80, 4'hC, 1'b0, 1'b0, 32'h00000000};
    tbl[7] = '{1'b1, 32'h40, 4'h0, 1'b0, 1'b0, 32'h00000000};
    tbl[8] = '{1'b0, 32'h40, 4'hF, 1'b0, 1'b0, 32'h00000000};

    // Reset state
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_drain_valid", 64'(drain_valid), 64'd0);
    chk("rst_ld_hit", 64'({ld_hit, ld_hit_reserve}), 64'd0);
    chk("rst_ld_data", 64'(ld_data), 64'd0);
    apply_reset();

    // Youngest-wins / partial-hit lookups
    do_store(32'h40, 32'h11111111, 4'hF);
    do_store(32'h40, 32'h22222222, 4'h1);
    do_store(32'h80, 32'h0000ABCD, 4'h3);
    #2;
    chk("preload_count", 64'(count), 64'd3);
    for (int i = 0; i < 9; i++) begin
      ld_valid = tbl[i].v; ld_addr = tbl[i].a; ld_be = tbl[i].be;
      #2;
      chk($sformatf("ld%0d_hit", i), 64'(ld_hit), 64'(tbl[i].hit));
      chk($sformatf("ld%0d_reserve", i), 64'(ld_hit_reserve), 64'(tbl[i].res));
      chk($sformatf("ld%0d_data", i), 64'(ld_data), 64'(tbl[i].d));
      tick();
    end
    ld_valid = 1'b0;

    // Drain in issue order
    exp_a = '{32'h40, 32'h40, 32'h80};
    exp_d = '{32'h11111111, 32'h22222222, 32'h0000ABCD};
    exp_b = '{4'hF, 4'h1, 4'h3};
    drain_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("dr%0d_valid", i), 64'(drain_valid), 64'd1);
      chk($sformatf("dr%0d_addr", i), 64'(drain_addr), 64'(exp_a[i]));
      chk($sformatf("dr%0d_data", i), 64'(drain_data), 64'(exp_d[i]));
      chk($sformatf("dr%0d_be", i), 64'(drain_be), 64'(exp_b[i]));
      tick();
    end
    #2;
    chk("dr_empty", 64'(empty), 64'd1);
    apply_reset();

    // Fill to full, then pop with a pending 9th store
    for (int i = 0; i < 8; i++) do_store(32'h1000 + 32'(4*i), 32'h01010101 * 32'(i), 4'hF);
    #2;
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_st_ready", 64'(st_ready), 64'd0);
    chk("fill_count", 64'(count), 64'd8);
    st_valid = 1'b1; st_addr = 32'h2000; st_data = 32'hDEADBEEF; st_be = 4'hF;
    drain_ready = 1'b1;
    chk("bp_st_ready0", 64'(st_ready), 64'd0);
    chk("bp_head0", 64'(drain_addr), 64'h1000);
    tick();
    #2;
    chk("bp_st_ready1", 64'(st_ready), 64'd1);
    chk("bp_count1", 64'(count), 64'd7);
    chk("bp_head1", 64'(drain_addr), 64'h1004);
    tick();
    st_valid = 1'b0;
    #2;
    chk("bp_count2", 64'(count), 64'd7);
    for (int j = 0; j < 7; j++) begin
      chk($sformatf("bp_dr%0d_valid", j), 64'(drain_valid), 64'd1);
      chk($sformatf("bp_dr%0d_addr", j), 64'(drain_addr), (j < 6) ? 64'(32'h1008 + 32'(4*j)) : 64'h2000);
      chk($sformatf("bp_dr%0d_data", j), 64'(drain_data),
          (j < 6) ? 64'(32'h01010101 * 32'(j + 2)) : 64'hDEADBEEF);
      tick();
      #2;
    end
    chk("bp_empty", 64'(empty), 64'd1);
    apply_reset();

    // Coalescing into the youngest entry
    do_store(32'h100, 32'h0000BEEF, 4'h3);
    do_store(32'h200, 32'h00001234, 4'h3);
    do_store(32'h200, 32'hCAFE0000, 4'hC);
    #2;
    chk("coal_count", 64'(count), 64'd2);
    chk("nocoal_count", 64'(nc_count), 64'd3);
    drain_ready = 1'b1;
    chk("coal_dr0_addr", 64'(drain_addr), 64'h100);
    chk("coal_dr0_data", 64'(drain_data), 64'h0000BEEF);
    tick();
    #2;
    chk("coal_dr1_addr", 64'(drain_addr), 64'h200);
    chk("coal_dr1_data", 64'(drain_data), 64'hCAFE1234);
    chk("coal_dr1_be", 64'(drain_be), 64'hF);
    apply_reset();

    // Reset mid-operation discards buffered stores
    do_store(32'h500, 32'h5, 4'hF);
    do_store(32'h504, 32'h6, 4'hF);
    do_store(32'h508, 32'h7, 4'hF);
    #2;
    chk("mid_count", 64'(count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_st_ready", 64'(st_ready), 64'd1);
    chk("mid_rst_drain_valid", 64'(drain_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    drain_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("mid_nodrain%0d", i), 64'(drain_valid), 64'd0);
      tick();
    end
    apply_reset();

    // Sustained store + drain across pointer wrap, with same-cycle visibility
    do_store(32'h3000, 32'hA5000000, 4'hF);
    drain_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      st_valid = 1'b1;
      st_addr = 32'h3000 + 32'(4*(c + 1));
      st_data = 32'hA5000000 + 32'(c + 1);
      st_be = 4'hF;
      ld_valid = 1'b1; ld_be = 4'hF;
      ld_addr = (c % 2 == 0) ? st_addr : 32'h3000 + 32'(4*c);
      #2;
      chk($sformatf("wrap%0d_count", c), 64'(count), 64'd1);
      chk($sformatf("wrap%0d_addr", c), 64'(drain_addr), 64'(32'h3000 + 32'(4*c)));
      chk($sformatf("wrap%0d_data", c), 64'(drain_data), 64'(32'hA5000000 + 32'(c)));
      if (c % 2 == 0) begin
        chk($sformatf("wrap%0d_same_cycle_miss", c), 64'(ld_hit), 64'd0);
      end else begin
        chk($sformatf("wrap%0d_next_cycle_hit", c), 64'(ld_hit), 64'd1);
        chk($sformatf("wrap%0d_ld_data", c), 64'(ld_data), 64'(32'hA5000000 + 32'(c)));
      end
      tick();
    end
    st_valid = 1'b0; ld_valid = 1'b0;
    tick();
    #2;
    chk("wrap_empty", 64'(empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer_fwd.md
Name: store_buffer_fwd

Overview:
- Parametrised store buffer between the memory stage and the d-cache. Generalises the single-hit store-buffer lookup to a DEPTH-entry FIFO.
- Committed stores are queued with per-byte enables. Same-word stores are optionally coalesced.
- Stores drain in order to the d-cache through a valid/ready handshake.
- Loads get byte-granular, youngest-wins forwarding, with full-hit and partial-hit (reserve/stall) indication.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width; multiple of 8. BE_W = DATA_WIDTH/8; OFF = log2(BE_W).
- COALESCE_EN, 1, 1 = merge a store into the youngest entry when the word address matches

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request
- st_ready  out  1  buffer can accept a store
- st_addr  in  ADDR_WIDTH  store byte address; word = st_addr[ADDR_WIDTH-1:OFF]
- st_data  in  DATA_WIDTH  store data, lane-aligned
- st_be  in  BE_W  byte enables
- ld_valid  in  1  load lookup request
- ld_addr  in  ADDR_WIDTH  load byte address
- ld_be  in  BE_W  bytes the load needs
- ld_hit  out  1  every requested byte is forwarded
- ld_hit_reserve  out  1  some but not all requested bytes are buffered; load must stall
- ld_data  out  DATA_WIDTH  forwarded data; uncovered bytes read 0
- drain_valid  out  1  head entry presented to the d-cache
- drain_ready  in  1  d-cache accepts the head
- drain_addr  out  ADDR_WIDTH  head word address, offset bits 0
- drain_data  out  DATA_WIDTH  head data
- drain_be  out  BE_W  head byte enables
- count  out  log2(DEPTH)+1  occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH

Behaviour:
- Reset (async, rst_n low):
  - head = tail = count = 0; all entry valid bits cleared.
  - Outputs: st_ready=1, drain_valid=0, empty=1, full=0, ld_hit=0, ld_hit_reserve=0, ld_data=0.
  - Reset mid-operation discards all buffered stores; nothing drains.
- Storage: circular array of {word_addr, data, be}. Head = oldest entry, tail = next free slot. Pointers wrap modulo DEPTH.
- st_ready = !full, from registered state only. A drain in the same cycle does not make a full buffer accept a store.
- Store accept (st_valid && st_ready):
  - Coalesce case: COALESCE_EN=1, count >= 2, and the youngest entry (tail-1) has a matching word address. Bytes with st_be set overwrite the entry's data lanes, and be |= st_be. Count and tail are unchanged. The head entry is never coalesced, so the drain outputs stay stable while drain_valid is high.
  - Otherwise: write the entry at tail, tail++, count++.
- Drain:
  - drain_valid = !empty; drain_* reflect the head entry combinationally.
  - On drain_valid && drain_ready: head++, count--.
  - While drain_valid=1 and drain_ready=0, drain_* stay stable.
- Simultaneous new-entry store and drain: count unchanged; both pointers advance.
- Load lookup (combinational, 0-cycle latency, no state change):
  - For each byte lane b with ld_be[b]=1, search valid entries whose word address matches and whose be[b]=1. The youngest such entry (closest to tail-1) supplies byte b.
  - covered = set of requested lanes found.
  - ld_hit = ld_valid && ld_be != 0 && covered == ld_be.
  - ld_hit_reserve = ld_valid && covered != 0 && covered != ld_be.
  - ld_valid=0 forces ld_hit=0, ld_hit_reserve=0, ld_data=0.
- Visibility:
  - A store accepted this cycle is invisible to a load in the same cycle; it becomes visible the next cycle.
  - An entry draining this cycle is still visible this cycle.
- count, empty, full are registered-state derived; they update on the edge after the event.
- st_valid while full: the store is not accepted; the producer holds it.

Test Plan:
- Reset then idle: rst_n low mid-traffic with count=3 -> count=0, empty=1, st_ready=1, drain_valid=0 immediately; no drain after release.
- Fill/backpressure: DEPTH=8, 8 stores to distinct words with drain_ready=0 -> full=1, st_ready=0. Then drain_ready=1 plus a 9th store pending -> the store is accepted the cycle after the first pop; drain order matches issue order.
- Coalesce:
  - Store 0x100 be=0011 data=0x0000BEEF, then store 0x200, then store 0x200 be=1100 data=0xCAFE0000 -> count=2.
  - The 0x200 entry drains as data 0xCAFExxxx with be combining both stores.
  - With COALESCE_EN=0 -> count=3.
- Youngest-wins forward: store 0x40 0x11111111 be=1111, then 0x40 0x22222222 be=0001 (non-coalescing, first entry at head) -> load 0x40 be=1111 returns 0x11111122, ld_hit=1.
- Partial hit: only store 0x80 be=0011 buffered -> load 0x80 be=1111 gives ld_hit=0, ld_hit_reserve=1. Load 0x80 be=0001 gives ld_hit=1. Load 0x84 gives both 0.
- Wrap/concurrency: sustained store+drain every cycle for 3*DEPTH cycles -> count constant, pointers wrap, data integrity preserved. A same-cycle load to the just-stored address misses; the next cycle it hits.
